sw_array_feeder: RTL
====================

// Module: sw_array_feeder
// PURPOSE
//  Upstream sequencer for the SmithWatermanPE systolic chain. Loads one short read into the PEs, one
//  base per PE via S_out/store_S. Then streams the reference into PE0 (T_out/init_out) at one base/cycle.
//  Then drives a flush so the last reference base propagates to the final PE. One alignment per start.
// PARAMETERS
//  N_PE    8   number of PEs in the chain = max read length
//  BASE_W  2   base width; encoding A=00 C=01 G=10 T=11
//  LEN_W   16  reference length counter width
//  RL_W    4   read length width, $clog2(N_PE)+1
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        begin alignment; sampled in IDLE only
//  read_len   in   RL_W     read bases to load, 1..N_PE; latched on start
//  ref_len    in   LEN_W    reference bases to stream, >=1; latched on start
//  revcomp    in   1        load read reverse-complemented; latched on start (see CONFIGURATION)
//  read_valid in   1        read base available
//  read_base  in   BASE_W   read base
//  read_ready out  1        feeder accepts read base
//  ref_valid  in   1        reference base available
//  ref_base   in   BASE_W   reference base
//  ref_ready  out  1        feeder accepts reference base
//  S_out      out  BASE_W   base to all PE S_in
//  store_S    out  N_PE     one-hot; bit k loads S_out into PE k
//  T_out      out  BASE_W   to PE0 T_in
//  init_out   out  1        to PE0 init_in; 1 = valid reference base this cycle
//  busy       out  1        not IDLE
//  done       out  1        one-cycle pulse at end of flush
//  cfg_err    out  1        one-cycle pulse: start with read_len==0 or >N_PE or ref_len==0
//  underrun   out  1        sticky: ref_valid low mid-stream; cleared on next accepted start
// BEHAVIOUR
//  Reset: state IDLE; every output 0; counters 0. rst asserted mid-operation aborts immediately, no done.
//  FSM: IDLE -> LOAD -> STREAM -> FLUSH -> DONE -> IDLE.
//  IDLE: start with bad config -> cfg_err pulse next cycle, stay IDLE. Otherwise latch config, go LOAD.
//  LOAD: read_ready=1. Each read handshake (index k = 0..read_len-1) registers S_out=base and store_S=1<<k.
//    Both are visible the cycle after the handshake; store_S=0 when no handshake. After read_len handshakes -> STREAM.
//    PEs k>=read_len keep their previous S.
//  STREAM: ref_ready=1. Each handshake registers T_out=ref_base, init_out=1, one-cycle latency.
//    A cycle with ref_valid=0 is an underrun: init_out=0, underrun set, go FLUSH.
//    After ref_len handshakes -> FLUSH.
//  FLUSH: init_out=0, T_out holds its last value, ready outputs 0, for exactly N_PE cycles -> DONE.
//  DONE: done=1 for one cycle -> IDLE. start is ignored whenever busy=1.
//  Counters saturate-free: read counter RL_W bits, ref counter LEN_W bits, flush counter $clog2(N_PE)+1 bits.
//  ref_len is a full LEN_W value with no wrap; ref_len=2**LEN_W-1 is legal.
// CONFIGURATION
//  SW_FEEDER_REVCOMP_EN defined: with revcomp latched 1, the read base at handshake k is written to
//    PE read_len-1-k with S_out=~read_base (complement).
//  SW_FEEDER_REVCOMP_EN undefined: revcomp is ignored; loading is always forward and uncomplemented.
// STRUCTURE
//  sw_pkg: BASE_W, base encodings, feeder state enum, function comp_base().
//  Sub-module sw_onehot_dec: RL_W index -> N_PE one-hot, registered outside.
// TESTING
//  1 rst high 20ns, then low -> all outputs 0, busy=0. Drive rst high mid-STREAM -> IDLE, no done.
//  2 read ACACTA (00,01,00,01,11,00), read_len=6 -> store_S 01h,02h..20h in order, S_out matches.
//    Then ref ACAGACTA, ref_len=8 -> T_out=ref[i], init_out=1 for 8 cycles, then 8 flush cycles, done.
//  3 read_valid toggling 1/0 during LOAD -> store_S pulses only on handshakes; no extra writes.
//  4 ref_valid dropped at ref index 3 -> init_out=0 next cycle, underrun=1, 8 flush cycles, done.
//    underrun clears on next start.
//  5 start with read_len=0, then read_len=9, then ref_len=0 -> cfg_err pulse each, busy stays 0.
//  6 With SW_FEEDER_REVCOMP_EN and revcomp=1, read ACACTA -> first write store_S=20h with S_out=11.
//    Last write store_S=01h with S_out=11.

Source files
------------

// File: rtl/sw_pkg.sv
// sw_pkg: shared types and helpers for the Smith-Waterman array feeder
//   BASE_W          base width (A=00 C=01 G=10 T=11)
//   feeder_state_t  feeder FSM states
//   comp_base()     base complement (A<->T, C<->G)
package sw_pkg;
    localparam int BASE_W = 2;
    localparam logic [BASE_W-1:0] BASE_A = 2'b00;
    localparam logic [BASE_W-1:0] BASE_C = 2'b01;
    localparam logic [BASE_W-1:0] BASE_G = 2'b10;
    localparam logic [BASE_W-1:0] BASE_T = 2'b11;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } feeder_state_t;
    function automatic logic [BASE_W-1:0] comp_base(input logic [BASE_W-1:0] b);
        return ~b;
    endfunction
endpackage

// File: rtl/sw_onehot_dec.sv
// sw_onehot_dec: index to one-hot decoder, combinational
//   idx     in  IW  index, out-of-range gives all zeros
//   onehot  out N   bit idx set
module sw_onehot_dec #(
    parameter int N  = 8,
    parameter int IW = 4
) (
    input  logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);
    assign onehot = (idx < IW'(N)) ? N'(1) << idx : '0;
endmodule

// File: rtl/sw_array_feeder.sv
// sw_array_feeder: loads a read into the PE chain, streams the reference, then flushes
//   clk, rst                 clock, async active-high reset
//   start/read_len/ref_len   start an alignment (config latched in IDLE)
//   revcomp                  reverse-complement load, only with SW_FEEDER_REVCOMP_EN
//   read_valid/base/ready    read base handshake (LOAD)
//   ref_valid/base/ready     reference base handshake (STREAM)
//   S_out/store_S            read base and one-hot PE write strobe
//   T_out/init_out           reference base into PE0
//   busy/done/cfg_err        status; underrun sticky until next accepted start
module sw_array_feeder
    import sw_pkg::*;
#(
    parameter int N_PE  = 8,
    parameter int LEN_W = 16,
    parameter int RL_W  = $clog2(N_PE) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RL_W-1:0]   read_len,
    input  logic [LEN_W-1:0]  ref_len,
    input  logic              revcomp,
    input  logic              read_valid,
    input  logic [BASE_W-1:0] read_base,
    output logic              read_ready,
    input  logic              ref_valid,
    input  logic [BASE_W-1:0] ref_base,
    output logic              ref_ready,
    output logic [BASE_W-1:0] S_out,
    output logic [N_PE-1:0]   store_S,
    output logic [BASE_W-1:0] T_out,
    output logic              init_out,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              underrun
);
    localparam int FL_W = $clog2(N_PE) + 1;
    feeder_state_t     state, state_d;
    logic [RL_W-1:0]   rd_cnt, rd_cnt_d, len_q, len_d, wr_idx;
    logic [LEN_W-1:0]  ref_cnt, ref_cnt_d, ref_len_q, ref_len_d;
    logic [FL_W-1:0]   fl_cnt, fl_cnt_d;
    logic              rc_q, rc_d;
    logic [BASE_W-1:0] s_d, t_d, wr_base;
    logic [N_PE-1:0]   store_d, onehot;
    logic              init_d, done_d, cfg_err_d, underrun_d, bad_cfg;

    assign bad_cfg    = (read_len == '0) || (read_len > RL_W'(N_PE)) || (ref_len == '0);
    assign read_ready = (state == ST_LOAD);
    assign ref_ready  = (state == ST_STREAM);
    assign busy       = (state != ST_IDLE);

`ifdef SW_FEEDER_REVCOMP_EN
    assign wr_idx  = rc_q ? len_q - rd_cnt - RL_W'(1) : rd_cnt;
    assign wr_base = rc_q ? comp_base(read_base) : read_base;
`else
    logic unused_rc;
    assign unused_rc = rc_q;
    assign wr_idx    = rd_cnt;
    assign wr_base   = read_base;
`endif

    sw_onehot_dec #(.N(N_PE), .IW(RL_W)) u_dec (
        .idx    (wr_idx),
        .onehot (onehot)
    );

    always_comb begin
        state_d    = state;
        rd_cnt_d   = rd_cnt;
        ref_cnt_d  = ref_cnt;
        fl_cnt_d   = fl_cnt;
        len_d      = len_q;
        ref_len_d  = ref_len_q;
        rc_d       = rc_q;
        s_d        = S_out;
        t_d        = T_out;
        store_d    = '0;
        init_d     = init_out;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        underrun_d = underrun;
        case (state)
            ST_IDLE: begin
                if (start && bad_cfg) cfg_err_d = 1'b1;
                if (start && !bad_cfg) begin
                    len_d      = read_len;
                    ref_len_d  = ref_len;
                    rc_d       = revcomp;
                    rd_cnt_d   = '0;
                    ref_cnt_d  = '0;
                    fl_cnt_d   = '0;
                    underrun_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (read_valid) begin
                    s_d      = wr_base;
                    store_d  = onehot;
                    rd_cnt_d = rd_cnt + RL_W'(1);
                    state_d  = (rd_cnt == len_q - RL_W'(1)) ? ST_STREAM : ST_LOAD;
                end
            end
            ST_STREAM: begin
                init_d     = ref_valid;
                t_d        = ref_valid ? ref_base : T_out;
                ref_cnt_d  = ref_cnt + LEN_W'(ref_valid);
                underrun_d = underrun | ~ref_valid;
                state_d    = (!ref_valid || ref_cnt == ref_len_q - LEN_W'(1)) ? ST_FLUSH : ST_STREAM;
            end
            ST_FLUSH: begin
                init_d   = 1'b0;
                fl_cnt_d = fl_cnt + FL_W'(1);
                done_d   = (fl_cnt == FL_W'(N_PE - 1));
                state_d  = done_d ? ST_DONE : ST_FLUSH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_cnt    <= '0;
            ref_cnt   <= '0;
            fl_cnt    <= '0;
            len_q     <= '0;
            ref_len_q <= '0;
            rc_q      <= 1'b0;
            S_out     <= '0;
            store_S   <= '0;
            T_out     <= '0;
            init_out  <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_d;
            rd_cnt    <= rd_cnt_d;
            ref_cnt   <= ref_cnt_d;
            fl_cnt    <= fl_cnt_d;
            len_q     <= len_d;
            ref_len_q <= ref_len_d;
            rc_q      <= rc_d;
            S_out     <= s_d;
            store_S   <= store_d;
            T_out     <= t_d;
            init_out  <= init_d;
            done      <= done_d;
            cfg_err   <= cfg_err_d;
            underrun  <= underrun_d;
        end
    end
endmodule
